// File: rtl/div_seq_pkg.sv
// Shared constants for the EX-stage divide sequencer: state codes,
// ready/start encodings and the iteration count.
package div_seq_pkg;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [5:0] DivIterCnt = 6'd32;

    typedef enum logic [1:0] {
        ST_FREE   = DivFree,
        ST_BYZERO = DivByZero,
        ST_ON     = DivOn,
        ST_END    = DivEnd
    } div_state_t;

endpackage

// File: rtl/div_seq.sv
// Restoring DIV/DIVU sequencer returning {remainder, quotient} for HI/LO.
// Latency: ready_o DATA_W+1 edges after the accepting edge, 1 edge for divide-by-zero.
// Backpressure: stallreq_o holds the pipeline while start_i is high and no result is ready.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = int'(DivIterCnt)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    div_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   work;
    logic [DATA_W-1:0]   divisor;
    logic                neg_quot;
    logic                neg_rem;

    logic                dvd_neg;
    logic                dvs_neg;
    logic [DATA_W-1:0]   dvd_abs;
    logic [DATA_W-1:0]   dvs_abs;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign stallreq_o = start_i & ~ready_o;

    assign dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign dvd_abs = dvd_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign dvs_abs = dvs_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Trial subtraction of the divisor from the partial remainder; bit DATA_W is the borrow.
    assign diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

    assign quot     = work[DATA_W-1:0];
    assign rem      = work[2*DATA_W:DATA_W+1];
    assign quot_fix = neg_quot ? (~quot + 1'b1) : quot;
    assign rem_fix  = neg_rem  ? (~rem  + 1'b1) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                ST_FREE: begin
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= ST_BYZERO;
                        end else begin
                            state    <= ST_ON;
                            cnt      <= '0;
                            work     <= {{DATA_W{1'b0}}, dvd_abs, 1'b0};
                            divisor  <= dvs_abs;
                            // Sign fix-ups are captured now so later operand changes are ignored.
                            neg_quot <= dvd_neg ^ dvs_neg;
                            neg_rem  <= dvd_neg;
                        end
                    end
                end

                ST_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                    state    <= ST_END;
                end

                ST_ON: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        if (diff[DATA_W]) begin
                            work <= {work[2*DATA_W-1:0], 1'b0};
                        end else begin
                            work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= DivResultReady;
                        state    <= ST_END;
                    end
                end

                ST_END: begin
                    // Result is held until the pipeline advances and start_i drops.
                    if (start_i == DivStop || annul_i) begin
                        state    <= ST_FREE;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end

                default: begin
                    state <= ST_FREE;
                end
            endcase
        end
    end

endmodule
